// File: rtl/ysyx_25040101_imm_stage.sv
// ysyx_25040101_imm_stage
// Immediate-generation stage for the decode path. It forms the XLEN-wide
// immediate for the I/S/B/U/J/CSR-Z formats and the branch/jump target
// pc + imm. A two-entry (main + skid) buffer sits on the output side, so
// in_ready_o comes straight from a flop. Beats with a malformed format
// select still flow through: they carry imm 0, target pc and the illegal flag.

module ysyx_25040101_imm_stage #(
    parameter int XLEN     = 32,
    parameter bit ZICSR_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [24:0]     raw_imm_i,
    input  logic [5:0]      imm_type_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] target_o,
    output logic            illegal_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [5:0] SEL_I = 6'b100000;
    localparam logic [5:0] SEL_S = 6'b010000;
    localparam logic [5:0] SEL_B = 6'b001000;
    localparam logic [5:0] SEL_U = 6'b000100;
    localparam logic [5:0] SEL_J = 6'b000010;
    localparam logic [5:0] SEL_Z = 6'b000001;

    // True when exactly one bit of the select is set.
    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   main_imm_q, main_imm_d;
    logic [XLEN-1:0]   main_tgt_q, main_tgt_d;
    logic              main_ill_q, main_ill_d;
    logic [XLEN-1:0]   skid_imm_q, skid_imm_d;
    logic [XLEN-1:0]   skid_tgt_q, skid_tgt_d;
    logic              skid_ill_q, skid_ill_d;

    logic              legal_s;
    logic signed [31:0] imm32_s;
    logic [XLEN-1:0]   new_imm_s;
    logic [XLEN-1:0]   new_tgt_s;
    logic              accept_s;
    logic              take_s;

    // Form the 32-bit immediate. raw_imm_i[k] is instruction bit k+7, so
    // instruction bit 31 is raw_imm_i[24]. Every format is sign-extended from
    // bit 31 of this value; Z is at most 31, so it stays zero-extended.
    always_comb begin
        legal_s = is_onehot6(imm_type_i) && !((imm_type_i == SEL_Z) && !ZICSR_EN);
        imm32_s = 32'sd0;
        case (imm_type_i)
            SEL_I:   imm32_s = {{20{raw_imm_i[24]}}, raw_imm_i[24:13]};
            SEL_S:   imm32_s = {{20{raw_imm_i[24]}}, raw_imm_i[24:18], raw_imm_i[4:0]};
            SEL_B:   imm32_s = {{20{raw_imm_i[24]}}, raw_imm_i[0], raw_imm_i[23:18],
                                raw_imm_i[4:1], 1'b0};
            SEL_U:   imm32_s = {raw_imm_i[24:5], 12'd0};
            SEL_J:   imm32_s = {{12{raw_imm_i[24]}}, raw_imm_i[12:5], raw_imm_i[13],
                                raw_imm_i[23:14], 1'b0};
            SEL_Z:   imm32_s = {27'd0, raw_imm_i[12:8]};
            default: imm32_s = 32'sd0;
        endcase
    end

    // Widen to XLEN and form the target; an illegal beat carries imm 0 and target pc.
    always_comb begin
        if (legal_s) begin
            new_imm_s = XLEN'(imm32_s);
            new_tgt_s = pc_i + XLEN'(imm32_s);
        end else begin
            new_imm_s = {XLEN{1'b0}};
            new_tgt_s = pc_i;
        end
    end

    assign accept_s = in_valid_i && in_ready_q;
    assign take_s   = out_valid_q && out_ready_i;

    // Buffer FSM: next state and entry contents; flush overrides any transfer.
    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tgt_d = main_tgt_q;
        main_ill_d = main_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tgt_d = skid_tgt_q;
        skid_ill_d = skid_ill_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d    = ST_ONE;
                        main_imm_d = new_imm_s;
                        main_tgt_d = new_tgt_s;
                        main_ill_d = !legal_s;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && take_s) begin
                        state_d    = ST_ONE;
                        main_imm_d = new_imm_s;
                        main_tgt_d = new_tgt_s;
                        main_ill_d = !legal_s;
                    end else if (accept_s) begin
                        state_d    = ST_FULL;
                        skid_imm_d = new_imm_s;
                        skid_tgt_d = new_tgt_s;
                        skid_ill_d = !legal_s;
                    end else if (take_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (take_s) begin
                        state_d    = ST_ONE;
                        main_imm_d = skid_imm_q;
                        main_tgt_d = skid_tgt_q;
                        main_ill_d = skid_ill_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State and entry registers; reset empties the buffer and zeroes both entries.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_imm_q  <= {XLEN{1'b0}};
            main_tgt_q  <= {XLEN{1'b0}};
            main_ill_q  <= 1'b0;
            skid_imm_q  <= {XLEN{1'b0}};
            skid_tgt_q  <= {XLEN{1'b0}};
            skid_ill_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_imm_q  <= main_imm_d;
            main_tgt_q  <= main_tgt_d;
            main_ill_q  <= main_ill_d;
            skid_imm_q  <= skid_imm_d;
            skid_tgt_q  <= skid_tgt_d;
            skid_ill_q  <= skid_ill_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign imm_o       = main_imm_q;
    assign target_o    = main_tgt_q;
    assign illegal_o   = main_ill_q;

endmodule

// File: tb/tb_ysyx_25040101_imm_stage.sv
// Bench for ysyx_25040101_imm_stage: three instances (XLEN 32, XLEN 64, and
// XLEN 64 without Zicsr) share one stimulus stream.
module tb_ysyx_25040101_imm_stage;

    logic        clock = 1'b0;
    logic        reset, flush_s, in_valid_s, out_ready_s;
    logic [24:0] raw_s;
    logic [5:0]  typ_s;
    logic [63:0] pc_s;

    logic        rdy32, vld32, ill32, rdy64, vld64, ill64, rdyz, vldz, illz;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64, immz, tgtz;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } beat_t;
    beat_t q32[$], q64[$], qz[$];

    always #5 clock = ~clock;

    ysyx_25040101_imm_stage #(.XLEN(32), .ZICSR_EN(1'b1)) u32 (
        .clock(clock), .reset(reset), .flush_i(flush_s), .in_valid_i(in_valid_s),
        .in_ready_o(rdy32), .raw_imm_i(raw_s), .imm_type_i(typ_s), .pc_i(pc_s[31:0]),
        .out_valid_o(vld32), .out_ready_i(out_ready_s), .imm_o(imm32),
        .target_o(tgt32), .illegal_o(ill32));

    ysyx_25040101_imm_stage #(.XLEN(64), .ZICSR_EN(1'b1)) u64 (
        .clock(clock), .reset(reset), .flush_i(flush_s), .in_valid_i(in_valid_s),
        .in_ready_o(rdy64), .raw_imm_i(raw_s), .imm_type_i(typ_s), .pc_i(pc_s),
        .out_valid_o(vld64), .out_ready_i(out_ready_s), .imm_o(imm64),
        .target_o(tgt64), .illegal_o(ill64));

    ysyx_25040101_imm_stage #(.XLEN(64), .ZICSR_EN(1'b0)) u64z (
        .clock(clock), .reset(reset), .flush_i(flush_s), .in_valid_i(in_valid_s),
        .in_ready_o(rdyz), .raw_imm_i(raw_s), .imm_type_i(typ_s), .pc_i(pc_s),
        .out_valid_o(vldz), .out_ready_i(out_ready_s), .imm_o(immz),
        .target_o(tgtz), .illegal_o(illz));

    // Reference: the immediate as a signed integer value built from the
    // instruction fields, then reduced modulo 2^XLEN.
    function automatic void ref_model(input logic [24:0] raw, input logic [5:0] typ,
                                      input logic [63:0] pc, input bit x64, input bit zicsr,
                                      output logic [63:0] imm, output logic [63:0] tgt,
                                      output logic ill);
        logic [31:0] i;
        longint      v;
        logic [63:0] mask;
        i    = {raw, 7'b0000000};
        mask = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        ill  = ($countones(typ) != 1) || ((typ == 6'b000001) && !zicsr);
        v    = 0;
        if (!ill) begin
            if (typ[5]) v = longint'($signed(i)) >>> 20;
            if (typ[4]) v = (longint'($signed(i)) >>> 25) * 32 + longint'(i[11:7]);
            if (typ[3]) v = (i[31] ? -64'sd4096 : 64'sd0) + longint'(i[7]) * 2048
                            + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            if (typ[2]) v = longint'($signed(i & 32'hFFFF_F000));
            if (typ[1]) v = (i[31] ? -64'sd1048576 : 64'sd0) + longint'(i[19:12]) * 4096
                            + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            if (typ[0]) v = longint'(i[19:15]);
        end
        imm = v & mask;
        tgt = (pc + imm) & mask;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [5:0] t,
                         input logic [63:0] pc);
        in_valid_s = v;
        raw_s      = inst[31:7];
        typ_s      = t;
        pc_s       = pc;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush_s = 1'b0; out_ready_s = 1'b0;
        drive(1'b0, 32'd0, 6'd0, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({vld32, rdy32, imm32, tgt32, ill32} !== {1'b0, 1'b1, 32'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset32: got v%b r%b imm %h tgt %h ill %b, need v0 r1 0 0 0",
                     vld32, rdy32, imm32, tgt32, ill32);
        end
        checks++;
        if ({vld64, rdy64, imm64, tgt64, ill64} !== {1'b0, 1'b1, 64'd0, 64'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset64: got v%b r%b imm %h tgt %h ill %b, need v0 r1 0 0 0",
                     vld64, rdy64, imm64, tgt64, ill64);
        end
        reset = 1'b0;
    endtask

    logic [31:0] vi [9] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h800000B7,
                            32'h0080006F, 32'h000F8073, 32'h12345678, 32'h00800093, 32'hFFFFFFFF};
    logic [5:0]  vt [9] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010,
                            6'b000001, 6'b000011, 6'b100000, 6'b000000};
    logic [63:0] vp [9] = '{64'h80000000, 64'h40, 64'h80000010, 64'h0, 64'h100,
                            64'h200, 64'h1000, 64'hFFFFFFFC, 64'h55};
    logic [31:0] x32i [9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h80000000,
                              32'h8, 32'h1F, 32'h0, 32'h8, 32'h0};
    logic [31:0] x32t [9] = '{32'h7FFFFFFF, 32'h3C, 32'h8000000C, 32'h80000000,
                              32'h108, 32'h21F, 32'h1000, 32'h4, 32'h55};
    logic [63:0] x64i [9] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                              64'hFFFFFFFF80000000, 64'h8, 64'h1F, 64'h0, 64'h8, 64'h0};
    logic [63:0] x64t [9] = '{64'h7FFFFFFF, 64'h3C, 64'h8000000C, 64'hFFFFFFFF80000000,
                              64'h108, 64'h21F, 64'h1000, 64'h100000004, 64'h55};
    logic [2:0]  xill [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111,
                              3'b000, 3'b111};

    task automatic test_formats();
        logic [63:0] ezi, ezt;
        out_ready_s = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, vi[k], vt[k], vp[k]);
            step();
            ezi = xill[k][0] ? 64'd0 : x64i[k];
            ezt = xill[k][0] ? vp[k] : x64t[k];
            checks++;
            if ({vld32, imm32, tgt32, ill32} !== {1'b1, x32i[k], x32t[k], xill[k][2]}) begin
                errors++;
                $display("FAIL fmt32[%0d]: got v%b imm %h tgt %h ill %b, need v1 imm %h tgt %h ill %b",
                         k, vld32, imm32, tgt32, ill32, x32i[k], x32t[k], xill[k][2]);
            end
            checks++;
            if ({vld64, imm64, tgt64, ill64} !== {1'b1, x64i[k], x64t[k], xill[k][1]}) begin
                errors++;
                $display("FAIL fmt64[%0d]: got v%b imm %h tgt %h ill %b, need v1 imm %h tgt %h ill %b",
                         k, vld64, imm64, tgt64, ill64, x64i[k], x64t[k], xill[k][1]);
            end
            checks++;
            if ({vldz, immz, tgtz, illz} !== {1'b1, ezi, ezt, xill[k][0]}) begin
                errors++;
                $display("FAIL fmt64noz[%0d]: got v%b imm %h tgt %h ill %b, need v1 imm %h tgt %h ill %b",
                         k, vldz, immz, tgtz, illz, ezi, ezt, xill[k][0]);
            end
            drive(1'b0, 32'd0, 6'd0, 64'd0);
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] bi [3] = '{32'h00100093, 32'h00200093, 32'h00300093};
        int idx = 0;
        logic acc;
        out_ready_s = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, bi[idx], 6'b100000, 64'h1000);
            acc = rdy32;
            step();
            if (acc) idx++;
            checks++;
            if ({vld32, rdy32, imm32, tgt32} !== {1'b1, (c == 0), 32'd1, 32'h1001}) begin
                errors++;
                $display("FAIL bp_hold c%0d: got v%b r%b imm %h tgt %h, need v1 r%b imm 1 tgt 1001",
                         c, vld32, rdy32, imm32, tgt32, (c == 0));
            end
        end
        checks++;
        if (idx != 2) begin
            errors++;
            $display("FAIL bp_accepted: got %0d beats, need 2", idx);
        end
        out_ready_s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({vld32, imm32, tgt32} !== {1'b1, 32'(k + 1), 32'h1001 + 32'(k)}) begin
                errors++;
                $display("FAIL bp_order k%0d: got v%b imm %h tgt %h, need v1 imm %h",
                         k, vld32, imm32, tgt32, k + 1);
            end
            if (idx < 3) drive(1'b1, bi[idx], 6'b100000, 64'h1000);
            else drive(1'b0, 32'd0, 6'd0, 64'd0);
            acc = in_valid_s && rdy32;
            step();
            if (acc) idx++;
        end
        checks++;
        if (vld32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got v%b, need 0", vld32);
        end
    endtask

    task automatic test_flush();
        out_ready_s = 1'b0;
        drive(1'b1, 32'h00100093, 6'b100000, 64'h0); step();
        drive(1'b1, 32'h00200093, 6'b100000, 64'h0); step();
        drive(1'b1, 32'h00300093, 6'b100000, 64'h0);
        flush_s = 1'b1; out_ready_s = 1'b1;
        step();
        flush_s = 1'b0;
        checks++;
        if ({vld32, rdy32} !== 2'b01) begin
            errors++;
            $display("FAIL flush_full: got v%b r%b, need v0 r1", vld32, rdy32);
        end
        drive(1'b0, 32'd0, 6'd0, 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (vld32 !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost k%0d: got v%b imm %h, need v0", k, vld32, imm32);
            end
        end
        out_ready_s = 1'b0;
        drive(1'b1, 32'h00400093, 6'b100000, 64'h0); step();
        drive(1'b1, 32'h00500093, 6'b100000, 64'h0);
        flush_s = 1'b1;
        step();
        flush_s = 1'b0;
        drive(1'b0, 32'd0, 6'd0, 64'd0);
        out_ready_s = 1'b1;
        step();
        checks++;
        if ({vld32, rdy32} !== 2'b01) begin
            errors++;
            $display("FAIL flush_one: got v%b r%b imm %h, need v0 r1", vld32, rdy32, imm32);
        end
    endtask

    task automatic test_reset_mid();
        out_ready_s = 1'b0;
        drive(1'b1, 32'h00100093, 6'b100000, 64'h10); step();
        drive(1'b1, 32'h00200093, 6'b100000, 64'h10); step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({vld32, rdy32, imm32, tgt32, ill32, vld64, imm64, tgt64} !==
            {1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_mid: got v%b r%b imm %h tgt %h ill %b v64 %b imm64 %h tgt64 %h",
                     vld32, rdy32, imm32, tgt32, ill32, vld64, imm64, tgt64);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(1'b1, 32'hFFF00093, 6'b100000, 64'h80000000);
        out_ready_s = 1'b1;
        step();
        checks++;
        if ({vld32, imm32, tgt32} !== {1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF}) begin
            errors++;
            $display("FAIL reset_first: got v%b imm %h tgt %h, need v1 FFFFFFFF 7FFFFFFF",
                     vld32, imm32, tgt32);
        end
        drive(1'b0, 32'd0, 6'd0, 64'd0);
        step();
    endtask

    task automatic test_random();
        beat_t b32, b64, bz, e;
        logic  acc, take;
        reset = 1'b1; flush_s = 1'b0;
        step();
        reset = 1'b0;
        q32.delete(); q64.delete(); qz.delete();
        for (int c = 0; c < 400; c++) begin
            e = (q32.size() != 0) ? q32[0] : '0;
            checks++;
            if (vld32 !== (q32.size() != 0) || rdy32 !== (q32.size() < 2) ||
                (q32.size() != 0 && {imm32, tgt32, ill32} !== {e.imm[31:0], e.tgt[31:0], e.ill})) begin
                errors++;
                $display("FAIL rand32 c%0d: got v%b r%b imm %h tgt %h ill %b, need v%b imm %h tgt %h ill %b",
                         c, vld32, rdy32, imm32, tgt32, ill32, q32.size() != 0,
                         e.imm[31:0], e.tgt[31:0], e.ill);
            end
            e = (q64.size() != 0) ? q64[0] : '0;
            checks++;
            if (vld64 !== (q64.size() != 0) ||
                (q64.size() != 0 && {imm64, tgt64, ill64} !== {e.imm, e.tgt, e.ill})) begin
                errors++;
                $display("FAIL rand64 c%0d: got v%b imm %h tgt %h ill %b, need imm %h tgt %h ill %b",
                         c, vld64, imm64, tgt64, ill64, e.imm, e.tgt, e.ill);
            end
            e = (qz.size() != 0) ? qz[0] : '0;
            checks++;
            if (vldz !== (qz.size() != 0) ||
                (qz.size() != 0 && {immz, tgtz, illz} !== {e.imm, e.tgt, e.ill})) begin
                errors++;
                $display("FAIL rand64noz c%0d: got v%b imm %h tgt %h ill %b, need imm %h tgt %h ill %b",
                         c, vldz, immz, tgtz, illz, e.imm, e.tgt, e.ill);
            end
            in_valid_s  = ($urandom_range(0, 3) != 0);
            out_ready_s = ($urandom_range(0, 3) != 0);
            flush_s     = ($urandom_range(0, 31) == 0);
            raw_s       = 25'($urandom);
            if ($urandom_range(0, 7) == 0) typ_s = 6'($urandom);
            else typ_s = 6'b000001 << $urandom_range(0, 5);
            pc_s = {$urandom, $urandom};
            acc  = in_valid_s && (q32.size() < 2);
            take = out_ready_s && (q32.size() != 0);
            ref_model(raw_s, typ_s, pc_s, 1'b0, 1'b1, b32.imm, b32.tgt, b32.ill);
            ref_model(raw_s, typ_s, pc_s, 1'b1, 1'b1, b64.imm, b64.tgt, b64.ill);
            ref_model(raw_s, typ_s, pc_s, 1'b1, 1'b0, bz.imm, bz.tgt, bz.ill);
            step();
            if (flush_s) begin
                q32.delete(); q64.delete(); qz.delete();
            end else begin
                if (take) begin
                    void'(q32.pop_front()); void'(q64.pop_front()); void'(qz.pop_front());
                end
                if (acc) begin
                    q32.push_back(b32); q64.push_back(b64); qz.push_back(bz);
                end
            end
        end
        flush_s = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25040101_imm_stage.md
# ysyx_25040101_imm_stage

Registered, parametrised immediate-generation stage for the nebula-core decode path. It sits between instruction fetch and the operand/branch units. For each accepted instruction it produces the XLEN-wide immediate for one of six formats (I, S, B, U, J, CSR-Z) and the precomputed target `pc + imm`. It flags malformed format selects and decouples both sides with a valid/ready two-entry skid buffer, so `in_ready` is a pure register output.

## Interface
- `XLEN`, default 32: datapath width; 32 or 64 only.
- `ZICSR_EN`, default 1: when 0, the Z format is treated as illegal.
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `flush_i`  in  1: synchronous flush; drops all buffered entries.
- `in_valid_i`  in  1: input beat valid.
- `in_ready_o`  out  1: stage can accept a beat.
- `raw_imm_i`  in  25: instruction bits [31:7].
- `imm_type_i`  in  6: one-hot format select, bit5..0 = I, S, B, U, J, Z.
- `pc_i`  in  XLEN: instruction address.
- `out_valid_o`  out  1: output beat valid.
- `out_ready_i`  in  1: consumer accepts the beat.
- `imm_o`  out  XLEN: extended immediate.
- `target_o`  out  XLEN: `pc + imm`, modulo 2^XLEN.
- `illegal_o`  out  1: the format select was not exactly one-hot, or was Z with `ZICSR_EN`=0.

## Operation
Immediate formation, with i = instruction and s = sign-extension of i[31] to XLEN:
- I: s : i[31:20]
- S: s : i[31:25], i[11:7]
- B: s : i[31], i[7], i[30:25], i[11:8], 0
- U: s : i[31:12], 12'b0 (sign-extended to 64 bits when `XLEN`=64)
- J: s : i[31], i[19:12], i[20], i[30:21], 0
- Z: zero-extended i[19:15]

Illegal select:
- Triggers when `imm_type_i` is all-zero, has more than one bit set, or is Z with `ZICSR_EN`=0.
- Result: `imm_o`=0, `target_o`=`pc_i`, `illegal_o`=1.
- The beat still flows through the stage; it is never dropped.

Buffering: two entries, main and skid, form a 3-state FSM.
- **EMPTY**: `out_valid_o`=0, `in_ready_o`=1. An accepted input moves the FSM to ONE.
- **ONE**: `out_valid_o`=1, `in_ready_o`=1.
  - Input accepted and output taken: stay in ONE; main is reloaded.
  - Input accepted, output not taken: the new beat goes to skid; move to FULL.
  - No input, output taken: move to EMPTY.
- **FULL**: `out_valid_o`=1, `in_ready_o`=0. When the output is taken, skid moves to main; go to ONE.

General rules:
- Handshake: a transfer occurs when valid && ready on the same edge.
- `in_ready_o` depends only on state, never combinationally on `out_ready_i`.
- `out_valid_o` and the output data are stable while `out_valid_o` && !`out_ready_i`.
- Ordering is strictly FIFO.
- Immediate and target are computed before registering. Outputs come straight from the main entry, with no logic after the flops.

## Timing
- Latency: a beat accepted at edge N is visible on the outputs after edge N.
- Throughput: one beat per cycle while `out_ready_i`=1.
- Reset (asynchronous assertion) forces:
  - FSM to EMPTY;
  - `out_valid_o`=0;
  - `in_ready_o`=1;
  - `imm_o`=0, `target_o`=0, `illegal_o`=0;
  - skid contents to 0.
- Reset asserted mid-transfer: all buffered beats are lost; no partial output.
- `flush_i`=1 at an edge:
  - FSM goes to EMPTY and both entries are invalidated.
  - Flush has priority over a simultaneous input accept or output take.
  - `in_ready_o` is still 1 during a flush cycle if the FSM allows it, but a beat presented in that cycle is discarded.
- Simultaneous accept and take in ONE: both happen; occupancy is unchanged.
- Wrap-around: `target_o` wraps modulo 2^XLEN with no carry-out flag. Example: pc 0xFFFFFFFC + 8 gives 0x00000004.

## Test plan
- I-type, XLEN=32: raw from 0xFFF00093, pc 0x80000000 -> `imm_o`=0xFFFFFFFF, `target_o`=0x7FFFFFFF, `illegal_o`=0, `out_valid_o` one cycle after accept.
- B-type: raw from 0xFE000EE3, pc 0x80000010 -> `imm_o`=0xFFFFFFFC, `target_o`=0x8000000C. J-type: 0x0080006F, pc 0x100 -> imm 0x8, target 0x108.
- XLEN=64: U from 0x800000B7 -> `imm_o`=0xFFFFFFFF80000000. Z from 0x000F8073 -> imm 0x1F. Z with `ZICSR_EN`=0 -> imm 0, `illegal_o`=1. `imm_type_i`=6'b000011 -> `illegal_o`=1, target = pc.
- Backpressure: stream beats A, B, C with `in_valid_i`=1 and `out_ready_i`=0 for 3 cycles ->
  - A and B are accepted, then `in_ready_o`=0 and C is held by the source;
  - A stays stable on the outputs;
  - after `out_ready_i`=1, the output order is A, B, C with no gaps.
- Flush: in FULL, assert `flush_i` together with `in_valid_i` -> next cycle `out_valid_o`=0, `in_ready_o`=1, and neither buffered beat nor the new beat ever appears.
- Reset mid-stream: assert `reset` asynchronously between edges while in FULL -> `out_valid_o` drops immediately, all outputs 0, `in_ready_o`=1. The first beat after release appears after one edge.
